// File: rtl/snn_seq_ctrl.sv
// snn_seq_ctrl -- inference sequencer for the 4-neuron spiking binary tile.
//
// Flow per inference: IDLE (accept request, latch vector) -> CLEAR (one cycle
// with the LIF membrane held in clear) -> RUN (tile_start high for T_WINDOW
// cycles) -> DRAIN (wait up to TIMEOUT cycles for tile_finish) -> HOLD
// (present the response until rsp_ready). A tile_finish seen in RUN or DRAIN
// ends the window early and jumps straight to HOLD.
//
// Ports:
//   CLK, nRST            clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready  request handshake, req_vector carries the inputs
//   tile_input_vector    latched request vector driven to the tile encoders
//   tile_start           encode/decode window enable
//   tile_lif_nrst        active-low LIF membrane clear
//   tile_output_vector   decoded tile outputs, tile_finish marks them valid
//   rsp_valid/rsp_ready  response handshake; rsp_vector, rsp_timeout payload
//   busy                 high whenever not IDLE
//   step_count           time step inside RUN, 0 elsewhere
//
// Optional build macro SNN_SEQ_PERF_EN adds perf_done / perf_timeout,
// saturating counters of accepted responses by completion kind.
// All outputs are registered.

module snn_seq_ctrl #(
    parameter int N_NEURONS = 4,
    parameter int DTT_WIDTH = 5,
    parameter int TTD_WIDTH = 5,
    parameter int T_WINDOW  = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [N_NEURONS*DTT_WIDTH-1:0] req_vector,
    output logic [N_NEURONS*DTT_WIDTH-1:0] tile_input_vector,
    output logic                           tile_start,
    output logic                           tile_lif_nrst,
    input  logic [N_NEURONS*TTD_WIDTH-1:0] tile_output_vector,
    input  logic                           tile_finish,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [N_NEURONS*TTD_WIDTH-1:0] rsp_vector,
    output logic                           rsp_timeout,
    output logic                           busy,
    output logic [7:0]                     step_count
`ifdef SNN_SEQ_PERF_EN
    ,
    output logic [15:0]                    perf_done,
    output logic [15:0]                    perf_timeout
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam logic [7:0] STEP_LAST  = 8'(T_WINDOW - 1);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] timer_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg         <= ST_IDLE;
            timer_reg         <= 8'd0;
            req_ready         <= 1'b1;
            tile_input_vector <= '0;
            tile_start        <= 1'b0;
            tile_lif_nrst     <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_vector        <= '0;
            rsp_timeout       <= 1'b0;
            busy              <= 1'b0;
            step_count        <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        tile_input_vector <= req_vector;
                        req_ready         <= 1'b0;
                        busy              <= 1'b1;
                        state_reg         <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    tile_lif_nrst <= 1'b1;
                    tile_start    <= 1'b1;
                    step_count    <= 8'd0;
                    state_reg     <= ST_RUN;
                end
                ST_RUN: begin
                    if (tile_finish) begin
                        // Early finish aborts the remaining window.
                        tile_start  <= 1'b0;
                        step_count  <= 8'd0;
                        rsp_vector  <= tile_output_vector;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_HOLD;
                    end else if (step_count == STEP_LAST) begin
                        tile_start <= 1'b0;
                        step_count <= 8'd0;
                        timer_reg  <= 8'd0;
                        state_reg  <= ST_DRAIN;
                    end else begin
                        step_count <= step_count + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // Finish wins even on the last timer cycle.
                    if (tile_finish || timer_reg == TIMER_LAST) begin
                        rsp_vector  <= tile_output_vector;
                        rsp_timeout <= ~tile_finish;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_HOLD;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        rsp_timeout   <= 1'b0;
                        tile_lif_nrst <= 1'b0;
                        req_ready     <= 1'b1;
                        busy          <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SNN_SEQ_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_done    <= 16'd0;
            perf_timeout <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_timeout) begin
                if (perf_timeout != 16'hFFFF) perf_timeout <= perf_timeout + 16'd1;
            end else begin
                if (perf_done != 16'hFFFF) perf_done <= perf_done + 16'd1;
            end
        end
    end
`endif

endmodule
